// File: rtl/sim_spi_host_pkg.sv
// Shared types and constants for the simulation SPI host engine.
//   - sim_spi_host_state_e : transaction FSM states
//   - ByteW                : width of one SPI byte
//   - cnt_width()          : counter width able to hold 0..n-1 (at least 1 bit)
package sim_spi_host_pkg;

    localparam int unsigned ByteW = 8;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StShift,
        StByteDone,
        StWait,
        StHold,
        StGap
    } sim_spi_host_state_e;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sim_spi_host_sck_gen.sv
// SCK generator for the SPI host: ClkDiv clk_i cycles low, then ClkDiv cycles high,
// repeating while enabled. Disabled, it parks with SCK low at the start of a low phase.
// Ports:
//   clk_i   clock
//   rst_i   synchronous active-high reset
//   en_i    run the divider (only while shifting)
//   sck_o   serial clock, idles low
//   rise_o  first cycle of a high phase (SDO sample point)
//   fall_o  last cycle of a high phase (SCK goes low on the next edge)
module sim_spi_host_sck_gen
    import sim_spi_host_pkg::*;
#(
    parameter int unsigned ClkDiv = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    output logic sck_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int unsigned CntW = cnt_width(ClkDiv);
    localparam logic [CntW-1:0] CntMax = CntW'(ClkDiv - 1);

    logic [CntW-1:0] cnt_q;
    logic            phase_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || !en_i) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else if (cnt_q == CntMax) begin
            cnt_q   <= '0;
            phase_q <= !phase_q;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign sck_o  = phase_q;
    assign rise_o = en_i && phase_q && (cnt_q == '0);
    assign fall_o = en_i && phase_q && (cnt_q == CntMax);

endmodule

// File: rtl/sim_spi_host.sv
// Synthesizable SPI mode-0 host engine for chip-level simulation. Bytes arrive on a
// valid/ready stream, are shifted out MSB first on SDI while SDO is sampled, and each
// received byte leaves on a single-entry valid/ready stream. CSB framing honours
// programmable setup, hold and idle times.
// Optional feature macro: SIM_SPI_HOST_SDO_CHECK_EN
//   defined   : SDO sampled while spi_sdo_en_i=0 reads as 0 and sets sticky err_o
//   undefined : SDO sampled raw, err_o tied low
// Ports:
//   clk_i, rst_i              clock, synchronous active-high reset
//   tx_valid_i/tx_data_i/tx_last_i/tx_ready_o   byte input stream (last ends the frame)
//   rx_valid_o/rx_data_o/rx_ready_i             received byte stream
//   busy_o                    any state other than Idle
//   err_o                     sticky SDO-not-driven error
//   spi_sck_o/spi_csb_o/spi_sdi_o               pads driven to the device
//   spi_sdo_i/spi_sdo_en_i    device data and its output enable
module sim_spi_host
    import sim_spi_host_pkg::*;
#(
    parameter int unsigned ClkDiv   = 4,
    parameter int unsigned CsbSetup = 2,
    parameter int unsigned CsbHold  = 2,
    parameter int unsigned CsbIdle  = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             tx_valid_i,
    input  logic [ByteW-1:0] tx_data_i,
    input  logic             tx_last_i,
    output logic             tx_ready_o,
    output logic             rx_valid_o,
    output logic [ByteW-1:0] rx_data_o,
    input  logic             rx_ready_i,
    output logic             busy_o,
    output logic             err_o,
    output logic             spi_sck_o,
    output logic             spi_csb_o,
    output logic             spi_sdi_o,
    input  logic             spi_sdo_i,
    input  logic             spi_sdo_en_i
);

    localparam int unsigned PhaseMax = (CsbSetup > CsbHold)
        ? ((CsbSetup > CsbIdle) ? CsbSetup : CsbIdle)
        : ((CsbHold > CsbIdle) ? CsbHold : CsbIdle);
    localparam int unsigned CntW    = cnt_width(PhaseMax);
    localparam int unsigned BitCntW = $clog2(ByteW);

    sim_spi_host_state_e state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;

    logic [ByteW-2:0]   tx_shift_q;  // bits still to be sent after the one on SDI
    logic [ByteW-1:0]   rx_shift_q;
    logic [ByteW-1:0]   rx_data_q;
    logic [BitCntW-1:0] bit_cnt_q;
    logic               last_q;
    logic               sdi_q;
    logic               rx_valid_q;

    logic sck, sck_rise, sck_fall;
    logic shifting;
    logic tx_hs;
    logic sdo_bit;

    assign shifting = (state_q == StShift);

    sim_spi_host_sck_gen #(
        .ClkDiv (ClkDiv)
    ) u_sck_gen (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .en_i   (shifting),
        .sck_o  (sck),
        .rise_o (sck_rise),
        .fall_o (sck_fall)
    );

    // A byte is only taken when the rx holding register is empty or draining this cycle,
    // so the received byte it produces always has somewhere to land.
    assign tx_ready_o = !rst_i && ((state_q == StIdle) || (state_q == StWait)) &&
                        (!rx_valid_q || rx_ready_i);
    assign tx_hs      = tx_valid_i && tx_ready_o;

    // FSM state register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // FSM next state; cnt_q times Setup, Hold and Gap and restarts on every transition
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        unique case (state_q)
            StIdle: begin
                if (tx_hs) state_d = StSetup;
            end
            StSetup: begin
                if (cnt_q == CntW'(CsbSetup - 1)) state_d = StShift;
                else                               cnt_d   = cnt_q + 1'b1;
            end
            StShift: begin
                if (sck_fall && (bit_cnt_q == '1)) state_d = StByteDone;
            end
            StByteDone: begin
                state_d = last_q ? StHold : StWait;
            end
            StWait: begin
                if (tx_hs) state_d = StShift;
            end
            StHold: begin
                if (cnt_q == CntW'(CsbHold - 1)) state_d = StGap;
                else                              cnt_d   = cnt_q + 1'b1;
            end
            StGap: begin
                if (cnt_q == CntW'(CsbIdle - 1)) state_d = StIdle;
                else                              cnt_d   = cnt_q + 1'b1;
            end
            default: state_d = StIdle;
        endcase
    end

`ifdef SIM_SPI_HOST_SDO_CHECK_EN
    logic err_q;

    assign sdo_bit = spi_sdo_en_i ? spi_sdo_i : 1'b0;
    assign err_o   = err_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else if (shifting && sck_rise && !spi_sdo_en_i) begin
            err_q <= 1'b1;
        end
    end
`else
    logic unused_sdo_en;

    assign unused_sdo_en = spi_sdo_en_i;
    assign sdo_bit       = spi_sdo_i;
    assign err_o         = 1'b0;
`endif

    // Shift datapath and rx holding register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tx_shift_q <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            bit_cnt_q  <= '0;
            last_q     <= 1'b0;
            sdi_q      <= 1'b0;
            rx_valid_q <= 1'b0;
        end else begin
            if (tx_hs) begin
                sdi_q      <= tx_data_i[ByteW-1];
                tx_shift_q <= tx_data_i[ByteW-2:0];
                last_q     <= tx_last_i;
                bit_cnt_q  <= '0;
            end else if (shifting && sck_fall) begin
                bit_cnt_q <= bit_cnt_q + 1'b1;
                // SDI keeps bit 0 after the final falling edge
                if (bit_cnt_q != '1) begin
                    sdi_q      <= tx_shift_q[ByteW-2];
                    tx_shift_q <= {tx_shift_q[ByteW-3:0], 1'b0};
                end
            end

            if (shifting && sck_rise) begin
                rx_shift_q <= {rx_shift_q[ByteW-2:0], sdo_bit};
            end

            if (state_q == StByteDone) begin
                rx_data_q  <= rx_shift_q;
                rx_valid_q <= 1'b1;
            end else if (rx_ready_i) begin
                rx_valid_q <= 1'b0;
            end
        end
    end

    assign rx_valid_o = rx_valid_q;
    assign rx_data_o  = rx_data_q;
    assign busy_o     = (state_q != StIdle);
    assign spi_sck_o  = sck;
    assign spi_sdi_o  = sdi_q;
    assign spi_csb_o  = (state_q == StIdle) || (state_q == StGap);

endmodule
